aha_tlx_lane_trainer: RTL
=========================

// Module: aha_tlx_lane_trainer
// PURPOSE
//  Sequences TLX link lane training after reset. Trains lanes one at a time:
//  drives a repeating serial pattern on the lane, finds the loopback delay, and
//  checks a run of consecutive error-free bits. Passing lanes are enabled.
//  Sits between the TLX control registers (START/PATTERN) and the per-lane
//  payload bit-0 training mux / lane-enable register.
// PARAMETERS
//  NUM_LANES  8   lanes trained, lane 0 first
//  PATTERN_W  32  training pattern length in bits; also the max delay searched
//  MATCH_CNT  64  consecutive matching bits required for a lane to pass
// PORTS
//  CLK          in   1          single clock
//  RESETn       in   1          asynchronous active-low reset
//  START        in   1          1-cycle pulse; honoured only in IDLE
//  ABORT        in   1          level; forces IDLE on the next edge
//  PATTERN      in   PATTERN_W  training word; sampled on START, sent MSB first
//  TX_DATA      out  NUM_LANES  training bit per lane; 0 on lanes not under training
//  RX_DATA      in   NUM_LANES  returned training bit per lane
//  LANE_ENABLE  out  NUM_LANES  bit set when that lane passes
//  LANE_PASS    out  NUM_LANES  pass status; bits of failed or untrained lanes are 0
//  CUR_LANE     out  LANE_W     lane under training; LANE_W = max(1, $clog2(NUM_LANES))
//  BUSY         out  1          1 in any state other than IDLE
//  DONE         out  1          1-cycle pulse after the last lane completes
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; pattern register 0; all counters 0.
//  Tx: bit pointer p runs PATTERN_W-1 down to 0, then wraps to PATTERN_W-1.
//   TX_DATA[CUR_LANE] = pat[p], registered. hist is a PATTERN_W-deep shift register
//   of the sent bits; hist[0] is the bit sent last cycle.
//  Delay d: an expected bit comes from hist[d], so RX_DATA is compared with the bit
//   sent d+1 cycles earlier.
//  FSM:
//   IDLE   on START (and ABORT=0): latch PATTERN; clear LANE_PASS, LANE_ENABLE and
//          CUR_LANE; set p = PATTERN_W-1; go to FILL.
//   FILL   send PATTERN_W bits to fill hist. Set d=0 and win=0; go to ALIGN.
//   ALIGN  compare RX_DATA[CUR_LANE] with hist[d] for PATTERN_W cycles.
//          - Window has no mismatches: lock d, set run=0, go to CHECK.
//          - Window has a mismatch and d < PATTERN_W-1: d++, open a new window.
//          - Window has a mismatch and d = PATTERN_W-1: lane fails, go to NEXT.
//          Worst case is PATTERN_W*PATTERN_W cycles.
//   CHECK  each cycle compare with hist[d].
//          - Match: run++. When run reaches MATCH_CNT, set LANE_PASS and
//            LANE_ENABLE for this lane, go to NEXT.
//          - Any mismatch: lane fails, go to NEXT. There is no retry.
//   NEXT   one cycle; TX_DATA all 0. If CUR_LANE = NUM_LANES-1, go to FINISH.
//          Otherwise CUR_LANE++, p = PATTERN_W-1, hist cleared, go to FILL.
//   FINISH one cycle; DONE=1; go to IDLE.
//  ABORT has priority over every transition. On ABORT: go to IDLE; TX_DATA cleared;
//   LANE_PASS and LANE_ENABLE keep partial results; no DONE pulse.
//  START while BUSY is ignored. START and ABORT in the same cycle in IDLE: stay IDLE.
//  A constant pattern (all 0s or all 1s) locks at d=0; the user must not rely on it.
//  CUR_LANE holds NUM_LANES-1 after completion until the next START.
//  Counter widths: d and p use $clog2(PATTERN_W); run uses $clog2(MATCH_CNT+1);
//   none may wrap beyond its terminal value.
// STRUCTURE
//  Package aha_tlx_train_pkg holds:
//   - the state enum {IDLE, FILL, ALIGN, CHECK, NEXT, FINISH};
//   - the default parameter constants.
//  Sub-module aha_tlx_train_lane_cmp holds:
//   - the pattern pointer, the hist shift register and the hist[d] mux comparator;
//   - output `match` (1 = RX_DATA bit equals hist[d]).
//  The top level holds the FSM, the counters, the lane select and the status registers.
// TESTING
//  Bench: loopback model with a programmable per-lane delay; RX = TX delayed L+1 cycles.
//  1 Reset, all lanes at L=0, PATTERN=32'hA5C3_1F07, START -> expect:
//    LANE_PASS = 8'hFF, LANE_ENABLE = 8'hFF, one DONE pulse, BUSY low after DONE.
//  2 Lane 3 at L=17, other lanes at L=0 -> expect:
//    lane 3 locks with d=17; LANE_PASS = 8'hFF.
//  3 Lane 5 RX stuck at 0 -> expect:
//    lane 5 fails after 32*32 ALIGN cycles; LANE_PASS = 8'hDF, LANE_ENABLE = 8'hDF;
//    DONE still pulses.
//  4 Flip one RX bit on lane 2 at run=40 during CHECK -> expect:
//    lane 2 fails; LANE_PASS[2] = 0; lane 3 starts on the next FILL.
//  5 ABORT while lane 4 is in CHECK -> expect:
//    IDLE on the next cycle; LANE_PASS = 8'h0F; TX_DATA = 0; no DONE.
//    Then START again -> status cleared and training restarts at lane 0.
//  6 START pulsed during ALIGN -> ignored.
//    RESETn asserted mid-run -> all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/aha_tlx_train_pkg.sv
// Shared types and default sizing for the TLX lane trainer.
package aha_tlx_train_pkg;

  localparam int unsigned NUM_LANES_DEF = 8;
  localparam int unsigned PATTERN_W_DEF = 32;
  localparam int unsigned MATCH_CNT_DEF = 64;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL   = 3'd1,
    ALIGN  = 3'd2,
    CHECK  = 3'd3,
    NEXT   = 3'd4,
    FINISH = 3'd5
  } state_e;

  // Lane index width, never narrower than one bit.
  function automatic int unsigned lane_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/aha_tlx_lane_trainer_if.sv
// Control/status and per-lane training bus between TLX registers and the lane trainer.
interface aha_tlx_lane_trainer_if
  import aha_tlx_train_pkg::*;
#(
  parameter int unsigned NUM_LANES = NUM_LANES_DEF,
  parameter int unsigned PATTERN_W = PATTERN_W_DEF
);
  localparam int unsigned LANE_W = lane_w(NUM_LANES);

  logic                 START;
  logic                 ABORT;
  logic [PATTERN_W-1:0] PATTERN;
  logic [NUM_LANES-1:0] TX_DATA;
  logic [NUM_LANES-1:0] RX_DATA;
  logic [NUM_LANES-1:0] LANE_ENABLE;
  logic [NUM_LANES-1:0] LANE_PASS;
  logic [LANE_W-1:0]    CUR_LANE;
  logic                 BUSY;
  logic                 DONE;

  modport master (
    output START, ABORT, PATTERN, RX_DATA,
    input  TX_DATA, LANE_ENABLE, LANE_PASS, CUR_LANE, BUSY, DONE
  );

  modport slave (
    input  START, ABORT, PATTERN, RX_DATA,
    output TX_DATA, LANE_ENABLE, LANE_PASS, CUR_LANE, BUSY, DONE
  );

endinterface

// File: rtl/aha_tlx_train_lane_cmp.sv
// Pattern bit pointer, sent-bit history and delayed-bit comparator for the lane
// currently under training.
module aha_tlx_train_lane_cmp
  import aha_tlx_train_pkg::*;
#(
  parameter int unsigned PATTERN_W = PATTERN_W_DEF,
  localparam int unsigned PTR_W    = $clog2(PATTERN_W)
) (
  input  logic                 CLK,
  input  logic                 RESETn,
  input  logic                 i_clear,
  input  logic                 i_send,
  input  logic [PATTERN_W-1:0] i_pattern,
  input  logic [PTR_W-1:0]     i_delay,
  input  logic                 i_rx_bit,
  output logic                 o_tx_bit_c,
  output logic                 match
);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(PATTERN_W - 1);

  logic [PTR_W-1:0]     r_ptr;
  logic [PATTERN_W-1:0] r_hist;
  logic                 r_sent;

  // r_sent mirrors the bit on the wire, so hist[0] always trails it by one cycle.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_ptr  <= '0;
      r_hist <= '0;
      r_sent <= 1'b0;
    end else if (i_clear) begin
      r_ptr  <= PTR_LAST;
      r_hist <= '0;
      r_sent <= 1'b0;
    end else if (i_send) begin
      r_ptr  <= (r_ptr == '0) ? PTR_LAST : r_ptr - PTR_W'(1);
      r_hist <= {r_hist[PATTERN_W-2:0], r_sent};
      r_sent <= i_pattern[r_ptr];
    end
  end

  assign o_tx_bit_c = i_pattern[r_ptr];
  assign match      = (i_rx_bit == r_hist[i_delay]);

endmodule

// File: rtl/aha_tlx_lane_trainer.sv
// TLX lane trainer: walks the lanes in order, finds each lane's loopback delay,
// then demands a run of clean bits before enabling the lane.
module aha_tlx_lane_trainer
  import aha_tlx_train_pkg::*;
#(
  parameter int unsigned NUM_LANES = NUM_LANES_DEF,
  parameter int unsigned PATTERN_W = PATTERN_W_DEF,
  parameter int unsigned MATCH_CNT = MATCH_CNT_DEF
) (
  input logic                   CLK,
  input logic                   RESETn,
  aha_tlx_lane_trainer_if.slave bus
);

  localparam int unsigned LANE_W = lane_w(NUM_LANES);
  localparam int unsigned PTR_W  = $clog2(PATTERN_W);
  localparam int unsigned RUN_W  = $clog2(MATCH_CNT + 1);

  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(PATTERN_W - 1);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(MATCH_CNT - 1);
  localparam logic [RUN_W-1:0]  RUN_FULL  = RUN_W'(MATCH_CNT);
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(NUM_LANES - 1);

  state_e               r_state, w_state_nxt;
  logic [PATTERN_W-1:0] r_pat, w_pat_nxt;
  logic [LANE_W-1:0]    r_cur, w_cur_nxt;
  logic [PTR_W-1:0]     r_d, w_d_nxt;
  logic [PTR_W-1:0]     r_win, w_win_nxt;
  logic [RUN_W-1:0]     r_run, w_run_nxt;
  logic                 r_err, w_err_nxt;
  logic [NUM_LANES-1:0] r_pass, w_pass_nxt;
  logic [NUM_LANES-1:0] r_tx, w_tx_nxt;
  logic                 r_busy, r_done;

  logic w_clear, w_send, w_tx_bit, w_match, w_rx_bit;

  assign w_rx_bit = bus.RX_DATA[r_cur];

  aha_tlx_train_lane_cmp #(.PATTERN_W(PATTERN_W)) u_cmp (
    .CLK        (CLK),
    .RESETn     (RESETn),
    .i_clear    (w_clear),
    .i_send     (w_send),
    .i_pattern  (r_pat),
    .i_delay    (r_d),
    .i_rx_bit   (w_rx_bit),
    .o_tx_bit_c (w_tx_bit),
    .match      (w_match)
  );

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state <= IDLE;
      r_pat   <= '0;
      r_cur   <= '0;
      r_d     <= '0;
      r_win   <= '0;
      r_run   <= '0;
      r_err   <= 1'b0;
      r_pass  <= '0;
      r_tx    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pat   <= w_pat_nxt;
      r_cur   <= w_cur_nxt;
      r_d     <= w_d_nxt;
      r_win   <= w_win_nxt;
      r_run   <= w_run_nxt;
      r_err   <= w_err_nxt;
      r_pass  <= w_pass_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= (w_state_nxt == FINISH);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pat_nxt   = r_pat;
    w_cur_nxt   = r_cur;
    w_d_nxt     = r_d;
    w_win_nxt   = r_win;
    w_run_nxt   = r_run;
    w_err_nxt   = r_err;
    w_pass_nxt  = r_pass;
    w_clear     = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (bus.START) begin
          w_pat_nxt   = bus.PATTERN;
          w_pass_nxt  = '0;
          w_cur_nxt   = '0;
          w_win_nxt   = '0;
          w_clear     = 1'b1;
          w_state_nxt = FILL;
        end
      end
      FILL: begin
        if (r_win == PTR_LAST) begin
          w_win_nxt   = '0;
          w_d_nxt     = '0;
          w_err_nxt   = 1'b0;
          w_state_nxt = ALIGN;
        end else begin
          w_win_nxt = r_win + PTR_W'(1);
        end
      end
      // One full pattern window per candidate delay; any miss moves to d+1.
      ALIGN: begin
        if (r_win != PTR_LAST) begin
          w_win_nxt = r_win + PTR_W'(1);
          w_err_nxt = r_err | ~w_match;
        end else if (!r_err && w_match) begin
          w_run_nxt   = '0;
          w_state_nxt = CHECK;
        end else if (r_d != PTR_LAST) begin
          w_d_nxt   = r_d + PTR_W'(1);
          w_win_nxt = '0;
          w_err_nxt = 1'b0;
        end else begin
          w_state_nxt = NEXT;
        end
      end
      CHECK: begin
        if (!w_match) begin
          w_state_nxt = NEXT;
        end else if (r_run == RUN_LAST) begin
          w_run_nxt         = RUN_FULL;
          w_pass_nxt[r_cur] = 1'b1;
          w_state_nxt       = NEXT;
        end else begin
          w_run_nxt = r_run + RUN_W'(1);
        end
      end
      NEXT: begin
        if (r_cur == LANE_LAST) begin
          w_state_nxt = FINISH;
        end else begin
          w_cur_nxt   = r_cur + LANE_W'(1);
          w_win_nxt   = '0;
          w_clear     = 1'b1;
          w_state_nxt = FILL;
        end
      end
      FINISH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    // Abort wins over everything, including a START in the same cycle.
    if (bus.ABORT) begin
      w_state_nxt = IDLE;
      w_pat_nxt   = r_pat;
      w_cur_nxt   = r_cur;
      w_pass_nxt  = r_pass;
      w_clear     = 1'b0;
    end
  end

  // Only drive the wire while staying inside the training states, so NEXT/IDLE see zeros.
  always_comb begin
    w_send = ((r_state == FILL) || (r_state == ALIGN) || (r_state == CHECK)) &&
             ((w_state_nxt == FILL) || (w_state_nxt == ALIGN) || (w_state_nxt == CHECK));
    w_tx_nxt = '0;
    if (w_send) w_tx_nxt[r_cur] = w_tx_bit;
  end

  assign bus.TX_DATA     = r_tx;
  assign bus.LANE_PASS   = r_pass;
  assign bus.LANE_ENABLE = r_pass;
  assign bus.CUR_LANE    = r_cur;
  assign bus.BUSY        = r_busy;
  assign bus.DONE        = r_done;

endmodule
